// File: rtl/input_pkg.sv
// Shared definitions for the input event capture block: event field widths
// and the frame sequencer state encoding.
package input_pkg;

  localparam int FRAME_W = 8;
  localparam int CH_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_SCAN  = 2'd2
  } state_t;

  // Saturating 8-bit increment used by the drop counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/event_fifo.sv
// Synchronous show-ahead FIFO: the head entry is always visible on o_data
// while o_empty is low; a pop on an empty FIFO is ignored.
module event_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [W-1:0]             i_data,
  input  logic                     i_pop,
  output logic [W-1:0]             o_data,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_pop;
  logic          w_push;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_MAX);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rptr];

  // A full FIFO still accepts a push when the same cycle frees a slot.
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/input_event_capture.sv
// Samples all joystick channels on each vblank rise, then scans them one per
// cycle and queues a {frame, ch, word} event for every channel that changed.
module input_event_capture
  import input_pkg::*;
#(
  parameter int NCH   = 6,
  parameter int JW    = 32,
  parameter int DEPTH = 16
) (
  input  logic                          clk_sys,
  input  logic                          reset,
  input  logic                          vblank,
  input  logic [NCH*JW-1:0]             joystick,
  input  logic                          rd,
  input  logic                          clr_ovf,
  output logic                          evt_valid,
  output logic [FRAME_W+CH_W+JW-1:0]    evt_data,
  output logic [$clog2(DEPTH):0]        evt_count,
  output logic [NCH*JW-1:0]             snapshot,
  output logic [7:0]                    frame,
  output logic                          overflow,
  output logic [7:0]                    drop_count,
  output logic [1:0]                    dbg_state,
  output logic [CH_W-1:0]               dbg_ch
);

  localparam int EW = FRAME_W + CH_W + JW;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NCH - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic              r_vb_q;
  logic              w_edge;
  logic [CH_W-1:0]   r_ch;
  logic [NCH*JW-1:0] r_snap;
  logic [NCH*JW-1:0] r_prev;
  logic [7:0]        r_frame;
  logic              r_ovf;
  logic [7:0]        r_drop;
  logic [JW-1:0]     w_cur;
  logic [JW-1:0]     w_prev_cur;
  logic              w_push;
  logic              w_drop;
  logic              w_full;
  logic              w_empty;

  // vb_q resets high so a vblank already high at reset release is not an edge.
  assign w_edge     = vblank & ~r_vb_q;
  assign w_cur      = r_snap[int'(r_ch)*JW +: JW];
  assign w_prev_cur = r_prev[int'(r_ch)*JW +: JW];
  assign w_push     = (r_state == ST_SCAN) && (w_cur != w_prev_cur);
  // Full implies non-empty, so an asserted rd is guaranteed to free a slot.
  assign w_drop     = w_push & w_full & ~rd;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_edge) w_state_next = ST_LATCH;
      ST_LATCH: w_state_next = ST_SCAN;
      ST_SCAN:  if (r_ch == LAST_CH) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_vb_q  <= 1'b1;
      r_ch    <= '0;
      r_snap  <= '0;
      r_prev  <= '0;
      r_frame <= '0;
    end else begin
      r_state <= w_state_next;
      r_vb_q  <= vblank;
      case (r_state)
        ST_LATCH: begin
          r_snap  <= joystick;
          r_frame <= r_frame + 8'd1;
          r_ch    <= '0;
        end
        ST_SCAN: begin
          if (w_push) r_prev[int'(r_ch)*JW +: JW] <= w_cur;
          r_ch <= (r_ch == LAST_CH) ? '0 : r_ch + CH_W'(1);
        end
        default: r_ch <= '0;
      endcase
    end
  end

  // A drop in the same cycle as clr_ovf wins and restarts the count at one.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_ovf  <= 1'b0;
      r_drop <= '0;
    end else if (w_drop) begin
      r_ovf  <= 1'b1;
      r_drop <= clr_ovf ? 8'd1 : sat_inc8(r_drop);
    end else if (clr_ovf) begin
      r_ovf  <= 1'b0;
      r_drop <= '0;
    end
  end

  // Read side: evt_valid acts as valid and rd as ready; an entry leaves the
  // FIFO only on a cycle with both high, and rd with evt_valid low is a no-op.
  event_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk_sys),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  ({r_frame, r_ch, w_cur}),
    .i_pop   (rd),
    .o_data  (evt_data),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (evt_count)
  );

  assign evt_valid  = ~w_empty;
  assign snapshot   = r_snap;
  assign frame      = r_frame;
  assign overflow   = r_ovf;
  assign drop_count = r_drop;
  assign dbg_state  = r_state;
  assign dbg_ch     = r_ch;

endmodule

// File: tb/tb_input_event_capture.sv
// Bench for input_event_capture: directed scenarios plus random traffic,
// compared every cycle against a frame-level model of the capture rules.
module tb_input_event_capture;

  localparam int NCH   = 6;
  localparam int JW    = 32;
  localparam int DEPTH = 16;
  localparam int EW    = 8 + 3 + JW;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic              clk_sys = 1'b0;
  logic              reset   = 1'b1;
  logic              vblank  = 1'b0;
  logic [NCH*JW-1:0] joystick = '0;
  logic              rd      = 1'b0;
  logic              clr_ovf = 1'b0;
  logic              evt_valid;
  logic [EW-1:0]     evt_data;
  logic [CW-1:0]     evt_count;
  logic [NCH*JW-1:0] snapshot;
  logic [7:0]        frame;
  logic              overflow;
  logic [7:0]        drop_count;
  logic [1:0]        dbg_state;
  logic [2:0]        dbg_ch;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  // model state
  logic [EW-1:0] exp_q[$];
  logic [JW-1:0] m_snap [NCH];
  logic [JW-1:0] m_prev [NCH];
  logic [7:0]    m_frame = '0;
  logic          m_ovf   = 1'b0;
  logic [7:0]    m_drop  = '0;
  logic          m_vbq   = 1'b1;
  int            m_pos   = -1;  // -1 idle, 0 latch cycle, 1..NCH scan of channel pos-1

  input_event_capture #(.NCH(NCH), .JW(JW), .DEPTH(DEPTH)) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .vblank     (vblank),
    .joystick   (joystick),
    .rd         (rd),
    .clr_ovf    (clr_ovf),
    .evt_valid  (evt_valid),
    .evt_data   (evt_data),
    .evt_count  (evt_count),
    .snapshot   (snapshot),
    .frame      (frame),
    .overflow   (overflow),
    .drop_count (drop_count),
    .dbg_state  (dbg_state),
    .dbg_ch     (dbg_ch)
  );

  // clock
  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    logic          push;
    logic          drop;
    logic [EW-1:0] pe;
    int            ch;
    if (reset) begin
      exp_q.delete();
      for (int k = 0; k < NCH; k++) begin
        m_snap[k] = '0;
        m_prev[k] = '0;
      end
      m_frame = '0;
      m_ovf   = 1'b0;
      m_drop  = '0;
      m_vbq   = 1'b1;
      m_pos   = -1;
      return;
    end
    push = 1'b0;
    drop = 1'b0;
    pe   = '0;
    if (m_pos == 0) begin
      for (int k = 0; k < NCH; k++) m_snap[k] = joystick[k*JW +: JW];
      m_frame = m_frame + 8'd1;
    end else if (m_pos > 0) begin
      ch = m_pos - 1;
      if (m_snap[ch] != m_prev[ch]) begin
        push = 1'b1;
        pe = {m_frame, 3'(ch), m_snap[ch]};
        m_prev[ch] = m_snap[ch];
      end
    end
    if (rd && exp_q.size() > 0) void'(exp_q.pop_front());
    if (push) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(pe);
      else drop = 1'b1;
    end
    if (drop) begin
      m_ovf  = 1'b1;
      m_drop = clr_ovf ? 8'd1 : ((m_drop == 8'hFF) ? m_drop : m_drop + 8'd1);
    end else if (clr_ovf) begin
      m_ovf  = 1'b0;
      m_drop = '0;
    end
    if (m_pos == -1) begin
      if (vblank && !m_vbq) m_pos = 0;
    end else if (m_pos == NCH) m_pos = -1;
    else m_pos = m_pos + 1;
    m_vbq = vblank;
  endtask

  task automatic compare();
    logic [NCH*JW-1:0] exp_snap;
    for (int k = 0; k < NCH; k++) exp_snap[k*JW +: JW] = m_snap[k];
    chk("evt_valid", 256'(evt_valid), 256'(exp_q.size() != 0));
    chk("evt_count", 256'(evt_count), 256'(exp_q.size()));
    if (exp_q.size() != 0) chk("evt_data", 256'(evt_data), 256'(exp_q[0]));
    chk("frame", 256'(frame), 256'(m_frame));
    chk("snapshot", 256'(snapshot), 256'(exp_snap));
    chk("overflow", 256'(overflow), 256'(m_ovf));
    chk("drop_count", 256'(drop_count), 256'(m_drop));
  endtask

  initial forever begin
    @(posedge clk_sys);
    model_step();
  end

  initial forever begin
    @(negedge clk_sys);
    if (chk_en) compare();
  end

  // driver tasks
  task automatic tick();
    @(negedge clk_sys);
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    vblank = 1'b0;
    rd = 1'b0;
    clr_ovf = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic pulse();
    tick();
    vblank = 1'b1;
    tick();
    vblank = 1'b0;
  endtask

  task automatic run_frame();
    pulse();
    repeat (NCH + 2) tick();
  endtask

  function automatic logic [JW-1:0] word_of(input int f, input int k);
    return JW'(f * 16 + k + 1);
  endfunction

  task automatic drain();
    int n;
    n = 0;
    rd = 1'b1;
    while (evt_valid && n < 64) begin
      tick();
      n++;
    end
    rd = 1'b0;
    chk("drain_empty", 256'(evt_valid), 256'(0));
  endtask

  initial begin
    logic [EW-1:0] exp_e;

    // reset state
    tick();
    tick();
    reset = 1'b0;
    chk_en = 1'b1;
    chk("rst_evt_valid", 256'(evt_valid), 256'(0));
    chk("rst_evt_count", 256'(evt_count), 256'(0));
    chk("rst_frame", 256'(frame), 256'(0));
    chk("rst_state", 256'(dbg_state), 256'(0));

    // single changed channel: one event, valid 4 cycles after the edge cycle
    joystick = '0;
    joystick[2*JW +: JW] = JW'(32'h10);
    pulse();
    repeat (3) tick();
    chk("single_valid_early", 256'(evt_valid), 256'(0));
    tick();
    chk("single_valid_on_time", 256'(evt_valid), 256'(1));
    exp_e = {8'd1, 3'd2, JW'(32'h10)};
    chk("single_data", 256'(evt_data), 256'(exp_e));
    repeat (NCH) tick();
    chk("single_count", 256'(evt_count), 256'(1));
    drain();

    // unchanged inputs over 3 frames
    do_reset();
    joystick = '0;
    repeat (3) run_frame();
    chk("unchanged_count", 256'(evt_count), 256'(0));
    chk("unchanged_frame", 256'(frame), 256'(3));

    // overflow: 18 events into 16 slots
    do_reset();
    for (int f = 1; f <= 3; f++) begin
      for (int k = 0; k < NCH; k++) joystick[k*JW +: JW] = word_of(f, k);
      run_frame();
    end
    chk("ovf_count", 256'(evt_count), 256'(16));
    chk("ovf_flag", 256'(overflow), 256'(1));
    chk("ovf_drops", 256'(drop_count), 256'(2));
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("clr_flag", 256'(overflow), 256'(0));
    chk("clr_drops", 256'(drop_count), 256'(0));

    // full FIFO, pop on the push cycle
    joystick[0 +: JW] = JW'(32'hABCD);
    pulse();
    tick();
    rd = 1'b1;
    tick();
    rd = 1'b0;
    chk("full_pp_count", 256'(evt_count), 256'(16));
    chk("full_pp_drops", 256'(drop_count), 256'(0));
    exp_e = {8'd1, 3'd1, word_of(1, 1)};
    chk("full_pp_head", 256'(evt_data), 256'(exp_e));
    repeat (NCH + 1) tick();

    // reset in the middle of a scan
    do_reset();
    for (int k = 0; k < NCH; k++) joystick[k*JW +: JW] = word_of(7, k);
    pulse();
    repeat (4) tick();
    chk("mid_scan_ch", 256'(dbg_ch), 256'(3));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_valid", 256'(evt_valid), 256'(0));
    chk("mid_rst_frame", 256'(frame), 256'(0));
    chk("mid_rst_ch", 256'(dbg_ch), 256'(0));
    pulse();
    tick();
    chk("restart_ch", 256'(dbg_ch), 256'(0));
    chk("restart_state", 256'(dbg_state), 256'(2));
    chk("restart_frame", 256'(frame), 256'(1));
    repeat (NCH + 1) tick();

    // vblank held high through reset release is not an edge
    tick();
    reset = 1'b1;
    vblank = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    repeat (4) tick();
    chk("vb_high_state", 256'(dbg_state), 256'(0));
    chk("vb_high_frame", 256'(frame), 256'(0));
    vblank = 1'b0;

    // 256 frames: frame counter wraps
    do_reset();
    joystick = '0;
    for (int f = 1; f <= 255; f++) begin
      joystick[0 +: JW] = JW'(f);
      pulse();
      for (int c = 0; c < NCH + 2; c++) begin
        rd = 1'($urandom_range(0, 1));
        tick();
      end
      rd = 1'b0;
    end
    drain();
    joystick[0 +: JW] = JW'(256);
    run_frame();
    chk("wrap_frame", 256'(frame), 256'(0));
    chk("wrap_count", 256'(evt_count), 256'(1));
    chk("wrap_evt_frame", 256'(evt_data[EW-1 -: 8]), 256'(0));
    chk("wrap_evt_ch", 256'(evt_data[JW +: 3]), 256'(0));

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      tick();
      vblank  = ($urandom_range(0, 3) == 0);
      rd      = ($urandom_range(0, 3) == 0);
      clr_ovf = ($urandom_range(0, 15) == 0);
      reset   = ($urandom_range(0, 299) == 0);
      for (int k = 0; k < NCH; k++)
        if ($urandom_range(0, 3) == 0) joystick[k*JW +: JW] = JW'($urandom_range(0, 3));
    end
    tick();
    reset = 1'b0;
    vblank = 1'b0;
    rd = 1'b0;
    clr_ovf = 1'b0;
    repeat (NCH + 3) tick();

    // report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/input_event_capture.md
INPUT_EVENT_CAPTURE -- requirements
Module: input_event_capture

Interface
REQ-001 SHALL have parameter NCH, default 6: number of joystick channels (1..8).
REQ-002 SHALL have parameter JW, default 32: bits per joystick word.
REQ-003 SHALL have parameter DEPTH, default 16: event FIFO entries (power of 2, >=2).
REQ-004 SHALL have port clk_sys, in, 1: sole clock; all logic rising-edge.
REQ-005 SHALL have port reset, in, 1: synchronous, active-high reset.
REQ-006 SHALL have port vblank, in, 1: frame strobe; a rising edge starts one sample frame.
REQ-007 SHALL have port joystick, in, NCH*JW: channel k at bits [k*JW +: JW].
REQ-008 SHALL have port rd, in, 1: pop the head event.
REQ-009 SHALL have port clr_ovf, in, 1: clear overflow and drop_count.
REQ-010 SHALL have port evt_valid, out, 1: FIFO non-empty.
REQ-011 SHALL have port evt_data, out, 8+3+JW: {frame[7:0], ch[2:0], word[JW-1:0]}, show-ahead head entry.
REQ-012 SHALL have port evt_count, out, $clog2(DEPTH)+1: FIFO occupancy.
REQ-013 SHALL have port snapshot, out, NCH*JW: last latched joystick words.
REQ-014 SHALL have port frame, out, 8: frame counter.
REQ-015 SHALL have port overflow, out, 1: sticky FIFO-full drop flag.
REQ-016 SHALL have port drop_count, out, 8: dropped events, saturating at 255.

Function
REQ-017 SHALL register vblank once (vb_q); edge = vblank & ~vb_q.
REQ-018 SHALL run FSM IDLE -> LATCH -> SCAN -> IDLE; IDLE->LATCH on edge.
REQ-019 SHALL in LATCH copy all of joystick into snapshot and increment frame (8-bit wrap 255->0), then enter SCAN with ch=0.
REQ-020 SHALL in SCAN examine one channel per cycle; if snapshot[ch] != prev[ch], push {frame, ch, snapshot[ch]} and set prev[ch] to snapshot[ch].
REQ-021 SHALL leave SCAN for IDLE after ch=NCH-1; a frame occupies NCH+1 cycles after the edge cycle.
REQ-022 SHALL ignore vblank edges while not in IDLE.
REQ-023 SHALL assert evt_valid the cycle after the push into an empty FIFO.
REQ-024 SHALL pop on rd when evt_valid=1; rd while empty SHALL be ignored with no state change.
REQ-025 SHALL on push while full with no pop in the same cycle: discard the event, set overflow, increment drop_count (saturating).
REQ-026 SHALL on push and pop in the same cycle while full: perform both; count unchanged, no drop.
REQ-027 SHALL on push and pop in the same cycle at any other occupancy: perform both; count unchanged.
REQ-028 SHALL on clr_ovf clear overflow and drop_count; a drop in the same cycle SHALL win (overflow=1, drop_count=1).
REQ-029 SHALL keep FIFO ordering strictly by push order.

Reset
REQ-030 SHALL on reset, including mid-SCAN, force: FSM=IDLE, ch=0, FIFO empty, evt_valid=0, evt_count=0, snapshot=0, prev=0, frame=0, overflow=0, drop_count=0, vb_q=1.
REQ-031 SHALL, because vb_q resets to 1, not treat vblank held high across reset release as an edge.

Structure
REQ-032 SHALL define event field widths and the FSM state enum in a shared package input_pkg.
REQ-033 SHALL implement storage as sub-module event_fifo (synchronous, show-ahead, parametrised width and depth, full/empty/count outputs).

Verification
REQ-034 SHALL cover: reset; joystick ch2=0x00000010, one vblank rise -> exactly one event {frame=1, ch=2, word=0x10}, evt_valid rises 4 cycles after the edge cycle.
REQ-035 SHALL cover: unchanged inputs over 3 frames -> no new events; frame=3 at the end.
REQ-036 SHALL cover: DEPTH=16, all 6 channels change every frame for 3 frames, no rd -> 16 stored, 2 dropped, overflow=1, drop_count=2; then clr_ovf -> overflow=0, drop_count=0.
REQ-037 SHALL cover: FIFO full, rd asserted on the cycle a push occurs -> evt_count stays 16, no drop, head advances.
REQ-038 SHALL cover: reset asserted during SCAN at ch=3 -> the next cycle shows evt_valid=0, frame=0, and a new edge restarts at ch=0.
REQ-039 SHALL cover: 256 frames each with a changed input -> frame wraps to 0 and the event frame field reads 0x00 on the 256th frame.
